// File: rtl/ws2811_led_driver.sv
// WS2811/WS2812 single-wire LED chain driver: fetches one RGB triple per LED,
// serializes it GRB MSB-first with fixed high times, then holds a latch gap.
module ws2811_led_driver #(
   parameter int unsigned NUM_LEDS     = 7,
   parameter int unsigned SYSTEM_CLOCK = 49_152_000
) (
   input  logic       sysclk,
   input  logic       reset,
   output logic [3:0] address,
   input  logic [7:0] red_in,
   input  logic [7:0] green_in,
   input  logic [7:0] blue_in,
   output logic       DO,
   output logic       frame_done
);

   localparam int unsigned CYC_BIT = SYSTEM_CLOCK / 800_000;
   localparam int unsigned T0H     = SYSTEM_CLOCK * 7 / 20_000_000;
   localparam int unsigned T1H     = SYSTEM_CLOCK * 7 / 10_000_000;
   localparam int unsigned CYC_RST = SYSTEM_CLOCK / 16_000;
   localparam int unsigned CNT_W   = 12;
   localparam int unsigned BIT_W   = 5;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned WORD_W  = 24;

   typedef enum logic [1:0] {
      ST_GAP,
      ST_LOAD,
      ST_SEND
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WORD_W-1:0]   shift_q, shift_d;
   logic                do_q, do_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    hi_len;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_GAP;
         cnt_q   <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         do_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         do_q    <= do_d;
         done_q  <= done_d;
      end
   end

   // Next state; the cycle counter restarts on every state entry and bit boundary.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      case (state_q)
         ST_GAP: begin
            if (cnt_q == CNT_W'(CYC_RST - 1)) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         ST_LOAD: begin
            // Second LOAD cycle: upstream has had one cycle to register the color.
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_SEND;
               cnt_d   = '0;
               bit_d   = '0;
               shift_d = {green_in, red_in, blue_in};
            end
         end
         ST_SEND: begin
            if (cnt_q == CNT_W'(CYC_BIT - 1)) begin
               cnt_d = '0;
               if (bit_q == BIT_W'(WORD_W - 1)) begin
                  if (idx_q == IDX_W'(NUM_LEDS - 1)) begin
                     state_d = ST_GAP;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_LOAD;
                     idx_d   = idx_q + IDX_W'(1);
                  end
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = {shift_q[WORD_W-2:0], 1'b0};
               end
            end
         end
         default: begin
            state_d = ST_GAP;
            cnt_d   = '0;
         end
      endcase
   end

   // Output level is decided from the upcoming counter/bit so DO is a clean flop.
   always_comb begin
      hi_len = shift_d[WORD_W-1] ? CNT_W'(T1H) : CNT_W'(T0H);
      do_d   = (state_d == ST_SEND) && (cnt_d < hi_len);
   end

   assign address    = idx_q;
   assign DO         = do_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_ws2811_led_driver.sv
// Bench for ws2811_led_driver: timeline model of the serial waveform checked
// every cycle, plus pulse-width decoding and frame timing pinned to literals.
module tb_ws2811_led_driver;

   localparam int CYC_BIT = 61;
   localparam int T0H     = 17;
   localparam int T1H     = 34;
   localparam int CYC_RST = 3072;
   localparam int NUM     = 7;
   localparam int LED_CYC = 2 + 24 * CYC_BIT;
   localparam int PERIOD  = NUM * LED_CYC + CYC_RST;

   logic       sysclk;
   logic       reset;
   logic [3:0] address;
   logic [7:0] red_in, green_in, blue_in;
   logic       DO;
   logic       frame_done;

   logic [7:0] exp_g [4][16];
   logic [7:0] exp_r [4][16];
   logic [7:0] exp_b [4][16];
   logic [7:0] cur_g [16];
   logic [7:0] cur_r [16];
   logic [7:0] cur_b [16];

   int  t;
   bit  running;
   int  base;
   int  total, bad, nprint;
   int  pw_q[$], rise_q[$], fd_q[$];
   int  hi_cnt;
   logic prev_do;

   ws2811_led_driver #(.NUM_LEDS(7), .SYSTEM_CLOCK(49_152_000)) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .address   (address),
      .red_in    (red_in),
      .green_in  (green_in),
      .blue_in   (blue_in),
      .DO        (DO),
      .frame_done(frame_done)
   );

   initial begin
      sysclk = 1'b0;
      forever #10 sysclk = ~sysclk;
   end

   // Expected outputs after the t-th rising edge since reset release.
   function automatic void model(input int tt, input int b, output logic d,
                                 output logic [3:0] a, output logic fd);
      int tp, f, p, led, q, bi, c, ei;
      logic [23:0] w;
      d = 1'b0; a = 4'd0; fd = 1'b0;
      if (tt < CYC_RST) return;
      tp = tt - CYC_RST;
      f  = tp / PERIOD;
      p  = tp % PERIOD;
      if (p < NUM * LED_CYC) begin
         led = p / LED_CYC;
         q   = p % LED_CYC;
         a   = 4'(led);
         if (q >= 2) begin
            bi = (q - 2) / CYC_BIT;
            c  = (q - 2) % CYC_BIT;
            ei = (b + f > 3) ? 3 : b + f;
            w  = {exp_g[ei][led], exp_r[ei][led], exp_b[ei][led]};
            d  = (c < (w[23-bi] ? T1H : T0H));
         end
      end else begin
         a  = 4'(NUM - 1);
         fd = (p == NUM * LED_CYC);
      end
   endfunction

   function automatic int decode(input int idx);
      int w;
      w = 0;
      for (int i = 0; i < 24; i++) w = (w << 1) | ((pw_q[idx+i] == T1H) ? 1 : 0);
      return w;
   endfunction

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic set_tables(input int ei);
      for (int i = 0; i < 16; i++) begin
         cur_g[i] = exp_g[ei][i];
         cur_r[i] = exp_r[ei][i];
         cur_b[i] = exp_b[ei][i];
      end
   endtask

   // Upstream pattern logic: presents the color for the current address.
   initial begin
      red_in = 8'd0; green_in = 8'd0; blue_in = 8'd0;
      forever begin
         @(negedge sysclk);
         green_in = cur_g[address];
         red_in   = cur_r[address];
         blue_in  = cur_b[address];
      end
   end

   // Per-cycle comparison against the timeline model.
   initial begin
      logic       ed, efd;
      logic [3:0] ea;
      t = 0; prev_do = 1'b0; hi_cnt = 0; nprint = 0;
      forever begin
         @(posedge sysclk);
         #1;
         if (!running) begin
            t = 0; prev_do = 1'b0; hi_cnt = 0;
         end else begin
            t++;
            model(t, base, ed, ea, efd);
            total++;
            if (DO !== ed || address !== ea || frame_done !== efd) begin
               bad++;
               if (nprint < 20) begin
                  nprint++;
                  $display("FAIL cycle t=%0d: DO=%b address=%0d frame_done=%b, expected DO=%b address=%0d frame_done=%b",
                           t, DO, address, frame_done, ed, ea, efd);
               end
            end
            if (DO === 1'b1 && prev_do === 1'b0) rise_q.push_back(t);
            if (DO === 1'b1) hi_cnt++;
            else if (prev_do === 1'b1) begin
               pw_q.push_back(hi_cnt);
               hi_cnt = 0;
            end
            if (frame_done === 1'b1) fd_q.push_back(t);
            prev_do = DO;
         end
      end
   end

   initial begin
      total = 0; bad = 0; running = 0; base = 0; reset = 1'b0;
      for (int e = 0; e < 4; e++)
         for (int i = 0; i < 16; i++) begin
            exp_g[e][i] = 8'd0; exp_r[e][i] = 8'd0; exp_b[e][i] = 8'd0;
         end
      exp_g[1][0] = 8'h80;
      for (int e = 2; e < 4; e++) begin
         exp_g[e][1] = 8'h32;
         exp_b[e][5] = 8'h5A;
      end
      exp_r[2][3] = 8'h11;
      exp_r[3][3] = 8'hA5;
      set_tables(0);

      repeat (3) @(negedge sysclk);
      chk("reset DO", longint'(DO), 0);
      chk("reset address", longint'(address), 0);
      chk("reset frame_done", longint'(frame_done), 0);

      pw_q.delete(); rise_q.delete(); fd_q.delete();
      reset = 1'b1;
      running = 1;

      wait (t >= PERIOD + 100);
      set_tables(1);
      wait (t >= 2 * PERIOD + 100);
      set_tables(2);
      // Middle of LED 3 SEND in frame 2.
      wait (t >= 34640);
      cur_r[3] = 8'hA5;
      // Frame 4, LED 2, 10th bit, 5 cycles into the high phase.
      wait (t >= 59896);
      #3;

      chk("first rise", rise_q[0], 3074);
      chk("bit period", rise_q[1] - rise_q[0], 61);
      for (int i = 0; i < 24; i++) chk("frame0 led0 zero pulse", pw_q[i], 17);
      chk("frame1 led0 bit0 width", pw_q[168], 34);
      chk("frame1 led0 bit1 width", pw_q[169], 17);
      chk("frame1 led1 word", decode(192), 0);
      chk("frame2 led1 word", decode(360), 24'h320000);
      chk("frame2 led3 word in flight", decode(408), 24'h001100);
      chk("frame3 led3 word", decode(576), 24'h00A500);
      chk("frame2 led5 word", decode(456), 24'h00005A);
      chk("first frame_done", fd_q[0], 13334);
      chk("frame_done spacing 1", fd_q[1] - fd_q[0], 13334);
      chk("frame_done spacing 2", fd_q[2] - fd_q[1], 13334);
      chk("frame_done spacing 3", fd_q[3] - fd_q[2], 13334);
      chk("gap after frame_done", rise_q[168] - fd_q[0], 3074);
      chk("pre-reset DO high", longint'(DO), 1);
      chk("pre-reset address", longint'(address), 2);

      reset = 1'b0;
      running = 0;
      #1;
      chk("async reset DO", longint'(DO), 0);
      chk("async reset address", longint'(address), 0);
      chk("async reset frame_done", longint'(frame_done), 0);
      repeat (3) @(negedge sysclk);
      chk("held reset DO", longint'(DO), 0);

      pw_q.delete(); rise_q.delete(); fd_q.delete();
      base = 3;
      reset = 1'b1;
      running = 1;
      wait (t >= PERIOD + 3100);

      chk("restart first rise", rise_q[0], 3074);
      chk("restart first pulse", pw_q[0], 17);
      chk("restart led3 word", decode(72), 24'h00A500);
      chk("restart frame_done", fd_q[0], 13334);
      chk("restart second frame rise", rise_q[168], 16408);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
